emit_asm: RTL and testbench

- Inverse of the assembly-file byte parser: consumes 128-bit AXI-Stream words and serializes each into a 17-byte record.
- Record format: one marker byte, then 16 payload bytes.
- Feeds a byte sink (UART TX, file dumper) so memory images can be streamed back out in the same format the loader accepts.
- A word with tuser=1 is a channel_update command and becomes an address record. A word with tuser=0 becomes a data record.

---
 rtl/asm_pkg.sv | 33 +++
 rtl/emit_asm_if.sv | 34 +++
 rtl/emit_asm.sv | 116 +++++++++++
 tb/tb_emit_asm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asm_pkg.sv
// Shared types and constants for the assembly-record emitter.
// Holds the channel_update command layout and record markers.
package asm_pkg;

  localparam int ASM_CHUNK_BYTES = 16;
  localparam int ASM_WORD_BITS = 8 * ASM_CHUNK_BYTES;

  localparam logic [7:0] ASM_ADDR_MARK = 8'h40;
  localparam logic [7:0] ASM_DATA_MARK = 8'h44;

  typedef struct packed {
    logic [26:0] addr;
    logic [26:0] stream_length;
    logic        wen;
  } channel_update_t;

  localparam int ASM_CMD_BITS = $bits(channel_update_t);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    BODY
  } emit_state_t;

  // Word address to zero-extended byte address.
  function automatic logic [ASM_WORD_BITS-1:0] byte_addr(
    input logic [26:0] a
  );
    byte_addr = '0;
    byte_addr[28:0] = {a, 2'b00};
  endfunction

endpackage

// File: rtl/emit_asm_if.sv
// Word-in / byte-out handshake bundle for emit_asm.
// slave = the emitter, master = the driver/sink side.
interface emit_asm_if;
  import asm_pkg::*;

  logic [ASM_WORD_BITS-1:0] axis_data;
  logic                     axis_tuser;
  logic                     axis_valid;
  logic                     axis_ready;
  logic [7:0]               fbyte;
  logic                     valid_fbyte;
  logic                     fbyte_ready;

  modport slave (
    input  axis_data,
    input  axis_tuser,
    input  axis_valid,
    output axis_ready,
    output fbyte,
    output valid_fbyte,
    input  fbyte_ready
  );

  modport master (
    output axis_data,
    output axis_tuser,
    output axis_valid,
    input  axis_ready,
    input  fbyte,
    input  valid_fbyte,
    output fbyte_ready
  );

endinterface

// File: rtl/emit_asm.sv
// Serializes 128-bit stream words into 17-byte marker+payload records.
// Optional EMIT_ASM_ADDR_ELIDE_EN drops redundant address records.
module emit_asm
  import asm_pkg::*;
#(
  parameter logic [7:0] ADDR_MARK = ASM_ADDR_MARK,
  parameter logic [7:0] DATA_MARK = ASM_DATA_MARK
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  emit_asm_if.slave bus
);

  emit_state_t              state;
  logic [ASM_WORD_BITS-1:0] payload;
  logic                     is_addr;
  logic [3:0]               byte_index;
  logic [3:0]               next_index;
  logic [7:0]               fbyte_q;
  logic                     valid_q;
  logic                     ready_q;
  logic                     accept;
  logic                     last;
  logic                     skip;
  channel_update_t          cmd;
  logic                     unused_cmd;

  assign cmd = channel_update_t'(bus.axis_data[ASM_CMD_BITS-1:0]);
  assign unused_cmd = ^{cmd.stream_length, cmd.wen};

  assign accept = bus.axis_valid && ready_q;
  assign next_index = byte_index + 4'd1;
  assign last = byte_index == 4'(ASM_CHUNK_BYTES - 1);

  assign bus.axis_ready = ready_q;
  assign bus.fbyte = fbyte_q;
  assign bus.valid_fbyte = valid_q;

`ifdef EMIT_ASM_ADDR_ELIDE_EN
  logic [26:0] expected_addr;
  logic        have_addr;

  assign skip = bus.axis_tuser && have_addr &&
                (cmd.addr == expected_addr);

  // Track the address the loader will be at after each record.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      expected_addr <= '0;
      have_addr <= 1'b0;
    end else if (state == IDLE && accept && !skip &&
                 bus.axis_tuser) begin
      expected_addr <= cmd.addr;
      have_addr <= 1'b1;
    end else if (state == BODY && bus.fbyte_ready &&
                 last && !is_addr) begin
      expected_addr <= expected_addr + 27'd4;
    end
  end
`else
  logic unused_flag;

  assign skip = 1'b0;
  assign unused_flag = is_addr;
`endif

  // Record FSM with registered handshake outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      byte_index <= '0;
      payload <= '0;
      is_addr <= 1'b0;
      fbyte_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept && !skip) begin
            payload <= bus.axis_tuser ?
                       byte_addr(cmd.addr) : bus.axis_data;
            is_addr <= bus.axis_tuser;
            fbyte_q <= bus.axis_tuser ? ADDR_MARK : DATA_MARK;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
            state <= MARK;
          end
        end
        MARK: begin
          if (bus.fbyte_ready) begin
            byte_index <= '0;
            fbyte_q <= payload[7:0];
            state <= BODY;
          end
        end
        BODY: begin
          if (bus.fbyte_ready) begin
            if (last) begin
              byte_index <= '0;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state <= IDLE;
            end else begin
              byte_index <= next_index;
              fbyte_q <= payload[{next_index, 3'b000} +: 8];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emit_asm.sv
// Directed bench for emit_asm: record format, stalls, reset, loopback.
// Build with EMIT_ASM_ADDR_ELIDE_EN to exercise address elision.
module tb_emit_asm;
  import asm_pkg::*;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b1;

  always #5 clk_in = ~clk_in;

  emit_asm_if bus ();

  emit_asm dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  typedef struct {
    logic [127:0] data;
    logic         tuser;
    bit           rnd;
    logic [135:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic prev_stall;
  logic [7:0] prev_byte;

`ifdef EMIT_ASM_ADDR_ELIDE_EN
  localparam int EL_BYTES = 51;
  localparam int EL_ADDR = 1;
`else
  localparam int EL_BYTES = 68;
  localparam int EL_ADDR = 2;
`endif

  task automatic chk(input string nm, input logic [135:0] act,
                     input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_cmd(input logic [26:0] a,
                                          input logic [26:0] sl,
                                          input logic w);
    channel_update_t c;
    c.addr = a;
    c.stream_length = sl;
    c.wen = w;
    return {73'd0, c};
  endfunction

  // Byte capture plus hold-while-stalled and ready-while-busy checks.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.valid_fbyte, 1);
        chk("hold_byte", bus.fbyte, prev_byte);
      end
      if (bus.valid_fbyte)
        chk("ready_busy", bus.axis_ready, 0);
      if (bus.valid_fbyte && bus.fbyte_ready)
        q.push_back(bus.fbyte);
      prev_stall <= bus.valid_fbyte && !bus.fbyte_ready;
      prev_byte <= bus.fbyte;
    end
  end

  task automatic send_word(input logic [127:0] d, input logic tu,
                           input bit emits);
    int c;
    bus.axis_data = d;
    bus.axis_tuser = tu;
    bus.axis_valid = 1'b1;
    c = 0;
    while (!bus.axis_ready && c < 100) begin
      @(posedge clk_in);
      #1;
      c++;
    end
    chk("send_timeout", c >= 100, 0);
    @(posedge clk_in);
    #1;
    bus.axis_valid = 1'b0;
    if (emits) begin
      chk("marker_valid", bus.valid_fbyte, 1);
      chk("marker_byte", bus.fbyte, tu ? 8'h40 : 8'h44);
    end else begin
      chk("elide_ready", bus.axis_ready, 1);
      chk("elide_quiet", bus.valid_fbyte, 0);
    end
  endtask

  task automatic collect(input int n, input bit rnd);
    int c;
    c = 0;
    while (q.size() < n && c < 1000) begin
      @(posedge clk_in);
      #1;
      if (rnd) bus.fbyte_ready = 1'($urandom_range(0, 1));
      c++;
    end
    bus.fbyte_ready = 1'b1;
    chk("collect_timeout", c >= 1000, 0);
  endtask

  task automatic pop_rec(output logic [135:0] r);
    r = 'x;
    for (int i = 0; i < 17; i++)
      r[8*i +: 8] = (q.size() > 0) ? q.pop_front() : 8'hxx;
  endtask

  vec_t tbl[7];
  logic [135:0] rec;
  logic [127:0] body;
  logic [127:0] lb_word[4];
  logic lb_tu[4];
  int v;
  int n40;
  int n44;

  initial begin
    tbl[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b0,
               {128'h0F0E0D0C0B0A09080706050403020100, 8'h44}};
    tbl[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 1'b1,
               {128'h0F0E0D0C0B0A09080706050403020100, 8'h44}};
    tbl[2] = '{mk_cmd(27'h1234, 27'h7FFFFFF, 1'b1), 1'b1, 1'b0,
               136'h48D040};
    tbl[3] = '{mk_cmd(27'h7FFFFFF, 27'h0, 1'b0), 1'b1, 1'b1,
               136'h1FFFFFFC40};
    tbl[4] = '{{128{1'b1}}, 1'b0, 1'b1, {{128{1'b1}}, 8'h44}};
    tbl[5] = '{128'h1, 1'b0, 1'b0, 136'h0144};
    tbl[6] = '{mk_cmd(27'h0, 27'h3, 1'b1), 1'b1, 1'b0, 136'h40};

    bus.axis_data = '0;
    bus.axis_tuser = 1'b0;
    bus.axis_valid = 1'b0;
    bus.fbyte_ready = 1'b1;

    #1 rst_n_in = 1'b0;
    #2;
    chk("rst_valid", bus.valid_fbyte, 0);
    chk("rst_fbyte", bus.fbyte, 0);
    chk("rst_ready", bus.axis_ready, 0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("ready_after_rst", bus.axis_ready, 1);

    // Address record with a sink that never stalls.
    send_word(mk_cmd(27'h400, 27'h55, 1'b1), 1'b1, 1'b1);
    v = 0;
    while (bus.valid_fbyte && v < 40) begin
      v++;
      @(posedge clk_in);
      #1;
    end
    chk("valid_run", v, 17);
    chk("ready_back", bus.axis_ready, 1);
    chk("addr_count", q.size(), 17);
    pop_rec(rec);
    chk("addr_rec", rec, 136'h100040);

    for (int i = 0; i < 7; i++) begin
      send_word(tbl[i].data, tbl[i].tuser, 1'b1);
      collect(17, tbl[i].rnd);
      pop_rec(rec);
      chk($sformatf("vec%0d", i), rec, tbl[i].exp);
    end

    // Reset after the fifth body byte drops the record.
    send_word(tbl[0].data, 1'b0, 1'b1);
    collect(6, 1'b0);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_valid", bus.valid_fbyte, 0);
    chk("mid_rst_fbyte", bus.fbyte, 0);
    chk("mid_rst_ready", bus.axis_ready, 0);
    rec = '0;
    for (int i = 0; i < 6; i++)
      rec[8*i +: 8] = q.pop_front();
    chk("partial_bytes", rec, 136'h040302010044);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    chk("no_residual", q.size(), 0);
    send_word(128'h00112233445566778899AABBCCDDEEFF, 1'b0, 1'b1);
    collect(17, 1'b0);
    pop_rec(rec);
    chk("post_rst_rec",
        rec, {128'h00112233445566778899AABBCCDDEEFF, 8'h44});

    // Loopback through a byte-level parser model.
    lb_tu = '{1'b1, 1'b0, 1'b0, 1'b0};
    lb_word[0] = '0;
    lb_word[1] = 128'hCAFEF00D_12345678_9ABCDEF0_0BADBEEF;
    lb_word[2] = 128'h80000000_00000000_00000000_00000001;
    lb_word[3] = 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3;
    send_word(mk_cmd(27'h1234, 27'h40, 1'b1), 1'b1, 1'b1);
    for (int i = 1; i < 4; i++)
      send_word(lb_word[i], 1'b0, 1'b1);
    collect(68, 1'b0);
    for (int r = 0; r < 4; r++) begin
      pop_rec(rec);
      body = rec[135:8];
      chk($sformatf("lb_tuser%0d", r), rec[7:0] == 8'h40, lb_tu[r]);
      if (r == 0) begin
        chk("lb_addr", body[28:2], 27'h1234);
        chk("lb_addr_hi", body[127:29], 0);
      end else begin
        chk($sformatf("lb_data%0d", r), body, lb_word[r]);
      end
    end

    // Repeated sequential address: elided only when the feature is on.
    send_word(mk_cmd(27'h100, 27'h9, 1'b1), 1'b1, 1'b1);
    send_word(lb_word[1], 1'b0, 1'b1);
    send_word(mk_cmd(27'h104, 27'h9, 1'b1), 1'b1, EL_ADDR == 2);
    send_word(lb_word[3], 1'b0, 1'b1);
    collect(EL_BYTES, 1'b0);
    repeat (40) @(posedge clk_in);
    #1;
    chk("elide_bytes", q.size(), EL_BYTES);
    n40 = 0;
    n44 = 0;
    while (q.size() >= 17) begin
      pop_rec(rec);
      if (rec[7:0] == 8'h40) n40++;
      if (rec[7:0] == 8'h44) n44++;
    end
    chk("elide_n40", n40, EL_ADDR);
    chk("elide_n44", n44, 2);
    q.delete();
    send_word(mk_cmd(27'h200, 27'h0, 1'b0), 1'b1, 1'b1);
    collect(17, 1'b0);
    pop_rec(rec);
    chk("new_addr_rec", rec, 136'h080040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
